// File: rtl/conv_window_buffer_pkg.sv
// Shared definitions for the sliding-window front end and convUnit:
// default element width, channel count, window edge, pixel type and the
// flattened-window element index helper.
package conv_pkg;

  localparam int CONV_DATA_WIDTH = 16;
  localparam int CONV_D          = 1;
  localparam int CONV_F          = 5;

  typedef logic [CONV_D*CONV_DATA_WIDTH-1:0] pixel_t;

  // Element index inside the flattened window; r=0 is the top row, c=0 the left column.
  function automatic int win_idx(input int ch, input int r, input int c, input int f = CONV_F);
    return (ch * f + r) * f + c;
  endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for conv_window_buffer.
// slave: the window buffer itself; master: the pixel source / window sink side.
interface conv_window_buffer_if
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int D          = CONV_D,
  parameter int F          = CONV_F
);

  logic                        in_valid;
  logic                        in_ready;
  logic [D*DATA_WIDTH-1:0]     pixel_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [D*F*F*DATA_WIDTH-1:0] window;
  logic                        frame_done;

  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid, window, frame_done
  );

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, window, frame_done
  );

endinterface

// File: rtl/conv_window_buffer_line_buffer.sv
// One image-row memory: synchronous write and combinational read at the
// same column address. Contents are deliberately not reset.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int WIDTH = $bits(pixel_t),
  parameter int DEPTH = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Row storage write port
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming FxF sliding-window generator (stride 1, no padding) feeding convUnit.
// F-1 line buffers plus an FxF shift-register window; valid/ready on both sides.
// Optional build macro CONV_WIN_STALL_CNT_EN adds a saturating stall_cycles
// counter of cycles with out_valid && !out_ready.
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int D          = CONV_D,
  parameter int F          = CONV_F,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32
) (
  input  logic                clk,
  input  logic                reset,
  conv_window_buffer_if.slave bus
`ifdef CONV_WIN_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  localparam int PW = D * DATA_WIDTH;
  localparam int NW = D * F * F * DATA_WIDTH;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] win_q [D][F][F];
  logic [DATA_WIDTH-1:0] win_d [D][F][F];

  logic [PW-1:0] lb_rd [F-1];
  logic [PW-1:0] lb_wd [F-1];

  logic accept, last_col, last_row, emit;

  assign bus.in_ready   = !out_valid_q || bus.out_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));
  assign emit     = accept && (row_q >= RW'(F - 1)) && (col_q >= CW'(F - 1));

  // Line buffers form a vertical shift chain per column; the newest row sits in lb[F-2].
  for (genvar k = 0; k < F - 1; k++) begin : g_lb
    if (k == F - 2) begin : g_top
      assign lb_wd[k] = bus.pixel_in;
    end else begin : g_mid
      assign lb_wd[k] = lb_rd[k+1];
    end
    conv_line_buffer #(.WIDTH(PW), .DEPTH(IMG_W)) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (col_q),
      .wdata (lb_wd[k]),
      .rdata (lb_rd[k])
    );
  end

  // Next window: shift left one column, new right column = line buffer column + incoming pixel
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int ch = 0; ch < D; ch++) begin
        for (int r = 0; r < F; r++) begin
          for (int c = 0; c < F - 1; c++) begin
            win_d[ch][r][c] = win_q[ch][r][c+1];
          end
        end
        for (int r = 0; r < F - 1; r++) begin
          win_d[ch][r][F-1] = lb_rd[r][PW-1-ch*DATA_WIDTH -: DATA_WIDTH];
        end
        win_d[ch][F-1][F-1] = bus.pixel_in[PW-1-ch*DATA_WIDTH -: DATA_WIDTH];
      end
    end
  end

  // Raster position, frame end pulse and output-valid handshake
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    if (accept) begin
      frame_done_d = last_col && last_row;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (emit)               out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
    else                    out_valid_d = out_valid_q;
  end

  // Flatten the window MSB-first so element 0 lands in the top bits
  always_comb begin
    bus.window = '0;
    for (int ch = 0; ch < D; ch++) begin
      for (int r = 0; r < F; r++) begin
        for (int c = 0; c < F; c++) begin
          bus.window[NW-1-win_idx(ch, r, c, F)*DATA_WIDTH -: DATA_WIDTH] = win_q[ch][r][c];
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q        <= '0;
      col_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '{default: '0};
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

`ifdef CONV_WIN_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where a window waits on downstream
  always_comb begin
    stall_d = stall_q;
    if (out_valid_q && !bus.out_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// Scoreboard bench for conv_window_buffer (D=1, F=5, 8x8 image, pixel = row*8+col + offset).
module tb_conv_window_buffer;
  import conv_pkg::*;

  localparam int W    = 16;
  localparam int D    = 1;
  localparam int F    = 5;
  localparam int IW   = 8;
  localparam int IH   = 8;
  localparam int WINW = D * F * F * W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_window_buffer_if #(.DATA_WIDTH(W), .D(D), .F(F)) bus ();
`ifdef CONV_WIN_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  conv_window_buffer #(.DATA_WIDTH(W), .D(D), .F(F), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CONV_WIN_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;
  int win_seen  = 0;
  int done_seen = 0;
  logic [WINW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic abort_run(input string name);
    bad++;
    total++;
    $display("FAIL %s timed out", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bound expired");
  endtask

  function automatic logic [WINW-1:0] model_win(input int off, input int rr, input int cc);
    logic [WINW-1:0] v;
    int idx;
    v = '0;
    for (int r = 0; r < F; r++) begin
      for (int c = 0; c < F; c++) begin
        idx = r * F + c;
        v[WINW-1-idx*W -: W] = W'(off + (rr - F + 1 + r) * IW + (cc - F + 1 + c));
      end
    end
    return v;
  endfunction

  task automatic push_frame(input int off);
    for (int rr = F - 1; rr < IH; rr++)
      for (int cc = F - 1; cc < IW; cc++)
        exp_q.push_back(model_win(off, rr, cc));
  endtask

  // Monitor: a window is taken when out_valid && out_ready at the coming edge
  task automatic monitor();
    logic [WINW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.frame_done) done_seen++;
        if (bus.out_valid && bus.out_ready) begin
          win_seen++;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL window_unexpected got=%h", bus.window);
          end else begin
            e = exp_q.pop_front();
            if (bus.window !== e) begin
              bad++;
              $display("FAIL window got=%h expected=%h", bus.window, e);
            end
          end
        end
      end
    end
  endtask

  // Drive one frame; stops before presenting (stop_r, stop_c) when given
  task automatic send_frame(input int off, input bit bubbles, input bit chk_first,
                            input int stop_r, input int stop_c);
    bit acc;
    int waitc;
    push_frame(off);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r == stop_r && c == stop_c) return;
        acc   = 1'b0;
        waitc = 0;
        while (!acc) begin
          bus.in_valid = bubbles ? ($urandom_range(0, 1) == 1) : 1'b1;
          bus.pixel_in = W'(off + r * IW + c);
          @(negedge clk);
          acc = bus.in_valid && bus.in_ready;
          if (chk_first && acc && r == F - 1 && c == F - 1)
            check("valid_before_first", 64'(bus.out_valid), 64'd0);
          @(posedge clk);
          #1;
          if (chk_first && acc && r == F - 1 && c == F - 1)
            check("first_valid_latency", 64'(bus.out_valid), 64'd1);
          waitc++;
          if (waitc > 2000) abort_run("pixel_accept");
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Hold off the first window for 27 cycles and watch it stay put
  task automatic stall_watch();
    logic [WINW-1:0] held;
    int waitc;
    waitc = 0;
    @(negedge clk);
    while (!bus.out_valid) begin
      @(negedge clk);
      waitc++;
      if (waitc > 2000) abort_run("stall_wait_valid");
    end
    held = bus.window;
    check("t2_elem0", 64'(held[WINW-1-0*W -: W]), 64'h0000);
    check("t2_elem12", 64'(held[WINW-1-12*W -: W]), 64'h0012);
    check("t2_elem24", 64'(held[WINW-1-24*W -: W]), 64'h0024);
    for (int i = 0; i < 27; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check("t2_window_stable", 64'(bus.window === held), 64'd1);
      end
      check("t2_in_ready_low", 64'(bus.in_ready), 64'd0);
      check("t2_valid_held", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  int w0, d0;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.pixel_in  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_frame_done", 64'(bus.frame_done), 64'd0);
    check("rst_window_zero", 64'(bus.window == '0), 64'd1);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    fork
      monitor();
    join_none

    // 1: plain ramp frame
    w0 = win_seen; d0 = done_seen;
    send_frame(0, 1'b0, 1'b1, -1, -1);
    drain();
    check("t1_windows", 64'(win_seen - w0), 64'd16);
    check("t1_frame_done", 64'(done_seen - d0), 64'd1);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // 2: backpressure on the first window
    w0 = win_seen; d0 = done_seen;
    bus.out_ready = 1'b0;
    fork
      send_frame(0, 1'b0, 1'b0, -1, -1);
      stall_watch();
    join
    drain();
    check("t2_windows", 64'(win_seen - w0), 64'd16);
    check("t2_frame_done", 64'(done_seen - d0), 64'd1);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef CONV_WIN_STALL_CNT_EN
    check("t6_stall_cycles", 64'(stall_cycles), 64'd27);
`endif

    // 3: random input bubbles
    w0 = win_seen; d0 = done_seen;
    send_frame(0, 1'b1, 1'b0, -1, -1);
    drain();
    check("t3_windows", 64'(win_seen - w0), 64'd16);
    check("t3_frame_done", 64'(done_seen - d0), 64'd1);
    check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

    // 4: two frames back to back, second offset by 0x40
    w0 = win_seen; d0 = done_seen;
    send_frame(0, 1'b0, 1'b0, -1, -1);
    send_frame(16'h40, 1'b0, 1'b0, -1, -1);
    drain();
    check("t4_windows", 64'(win_seen - w0), 64'd32);
    check("t4_frame_done", 64'(done_seen - d0), 64'd2);
    check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

    // 5: reset while pixel (5,3) is presented, then restart the frame
    w0 = win_seen; d0 = done_seen;
    send_frame(0, 1'b0, 1'b0, 5, 3);
    bus.in_valid = 1'b1;
    bus.pixel_in = W'(5 * IW + 3);
    check("t5_windows_before_abort", 64'(win_seen - w0), 64'd4);
    check("t5_window_nonzero", 64'(bus.window != '0), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("t5_async_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_async_window", 64'(bus.window == '0), 64'd1);
    check("t5_async_in_ready", 64'(bus.in_ready), 64'd1);
    check("t5_abort_no_done", 64'(done_seen - d0), 64'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    w0 = win_seen; d0 = done_seen;
    send_frame(0, 1'b0, 1'b1, -1, -1);
    drain();
    check("t5_windows", 64'(win_seen - w0), 64'd16);
    check("t5_frame_done", 64'(done_seen - d0), 64'd1);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
